not_logic_checker: RTL and testbench

Self-checking response monitor that sits directly downstream of the `not_logic` inverter. It samples each stimulus/response pair presented to and produced by the inverter, compares the response against the bitwise inverse of the stimulus, and keeps saturating pass/fail counts plus a sticky error flag over a start/stop-delimited check window. It replaces manual `$monitor` inspection with a synthesizable, cycle-accurate verdict that a bench or on-board logic can read.

---
 rtl/not_logic_checker.sv | 172 +++++++++++++++++
 tb/tb_not_logic_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/not_logic_checker.sv
// not_logic_checker: response monitor for the not_logic inverter.
// Accepts stimulus/response pairs during a start/stop window. It checks each
// pair against resp == ~stim and keeps saturating pass/fail counts plus a
// sticky error flag.
// Optional feature macro: CHECKER_CAPTURE_EN adds first_fail_stim/first_fail_resp,
// which capture the first mismatching pair of the window.
module not_logic_checker #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] stim,
   input  logic [WIDTH-1:0] resp,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
`ifdef CHECKER_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] first_fail_stim,
   output logic [WIDTH-1:0] first_fail_resp
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   state_t           state_q, state_d;
   logic             start_acc;
   logic             accept;

   logic             vld_p1_q, vld_p1_d;
   logic [WIDTH-1:0] stim_p1_q, stim_p1_d;
   logic [WIDTH-1:0] resp_p1_q, resp_p1_d;
   logic             mismatch_p1;

   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             error_q, error_d;

   // A start is honoured only when no window is open.
   assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign accept    = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start wins over stop outside RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (stop)  state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Decoded status outputs.
   always_comb begin
      in_ready = (state_q == S_RUN);
      busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
      done     = (state_q == S_DONE);
   end

   // ---- stage 1: register the accepted pair ----
   always_comb begin
      vld_p1_d  = accept;
      stim_p1_d = accept ? stim : stim_p1_q;
      resp_p1_d = accept ? resp : resp_p1_q;
   end

   // Stage-1 valid is control and is reset; the data lanes are not.
   always_ff @(posedge clk) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= vld_p1_d;
      stim_p1_q <= stim_p1_d;
      resp_p1_q <= resp_p1_d;
   end

   // ---- stage 2: compare all lanes and update the verdict ----
   assign mismatch_p1 = (resp_p1_q != ~stim_p1_q);

   // Counter and sticky-error update; an accepted start clears the window.
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      error_d    = error_q;
      if (start_acc) begin
         pass_cnt_d = '0;
         fail_cnt_d = '0;
         error_d    = 1'b0;
      end else if (vld_p1_q) begin
         if (mismatch_p1) begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            error_d    = 1'b1;
         end else begin
            pass_cnt_d = sat_inc(pass_cnt_q);
         end
      end
   end

   // Verdict registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         error_q    <= error_d;
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
   assign error    = error_q;

`ifdef CHECKER_CAPTURE_EN
   logic [WIDTH-1:0] cap_stim_q, cap_stim_d;
   logic [WIDTH-1:0] cap_resp_q, cap_resp_d;

   // Load on the first mismatch of the window; error_q still low marks "first".
   always_comb begin
      cap_stim_d = cap_stim_q;
      cap_resp_d = cap_resp_q;
      if (start_acc) begin
         cap_stim_d = '0;
         cap_resp_d = '0;
      end else if (vld_p1_q && mismatch_p1 && !error_q) begin
         cap_stim_d = stim_p1_q;
         cap_resp_d = resp_p1_q;
      end
   end

   // Capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_stim_q <= '0;
         cap_resp_q <= '0;
      end else begin
         cap_stim_q <= cap_stim_d;
         cap_resp_q <= cap_resp_d;
      end
   end

   assign first_fail_stim = cap_stim_q;
   assign first_fail_resp = cap_resp_q;
`endif

endmodule

// File: tb/tb_not_logic_checker.sv
// Testbench for not_logic_checker: directed scenarios plus randomized traffic,
// checked every cycle against a window-level reference model.
module tb_not_logic_checker;
   localparam int WIDTH = 1;
   localparam int CNT_W = 3;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, start, stop, in_valid;
   logic [WIDTH-1:0] stim, resp;
   logic             in_ready, busy, done, error;
   logic [CNT_W-1:0] pass_cnt, fail_cnt;
`ifdef CHECKER_CAPTURE_EN
   logic [WIDTH-1:0] first_fail_stim, first_fail_resp;
`endif

   always #5 clk = ~clk;

   not_logic_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
      .stim(stim), .resp(resp), .in_ready(in_ready), .busy(busy), .done(done),
      .error(error), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef CHECKER_CAPTURE_EN
      , .first_fail_stim(first_fail_stim), .first_fail_resp(first_fail_resp)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: mode 0 idle, 1 run, 2 drain, 3 done.
   int               m_mode;
   int               m_pass, m_fail;
   bit               m_err;
   logic [WIDTH-1:0] m_cap_stim, m_cap_resp;
   logic [WIDTH-1:0] q_stim[$];
   logic [WIDTH-1:0] q_resp[$];

   task automatic model_clear();
      m_pass = 0; m_fail = 0; m_err = 0; m_cap_stim = '0; m_cap_resp = '0;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] s, r;
      if (rst) begin
         m_mode = 0; model_clear(); q_stim.delete(); q_resp.delete();
         return;
      end
      // Pair accepted on the previous edge becomes visible now.
      if (q_stim.size() > 0) begin
         s = q_stim.pop_front();
         r = q_resp.pop_front();
         if ((s ^ r) == {WIDTH{1'b1}}) begin
            if (m_pass < MAXC) m_pass++;
         end else begin
            if (!m_err) begin m_cap_stim = s; m_cap_resp = r; end
            m_err = 1;
            if (m_fail < MAXC) m_fail++;
         end
      end
      if (in_valid && m_mode == 1) begin
         q_stim.push_back(stim);
         q_resp.push_back(resp);
      end
      if ((m_mode == 0 || m_mode == 3) && start) begin
         m_mode = 1; model_clear();
      end else if (m_mode == 1 && stop) m_mode = 2;
      else if (m_mode == 2) m_mode = 3;
   endtask

   task automatic compare_all();
      check("in_ready", 32'(in_ready), 32'(m_mode == 1));
      check("busy",     32'(busy),     32'(m_mode == 1 || m_mode == 2));
      check("done",     32'(done),     32'(m_mode == 3));
      check("error",    32'(error),    32'(m_err));
      check("pass_cnt", 32'(pass_cnt), 32'(m_pass));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
`ifdef CHECKER_CAPTURE_EN
      check("cap_stim", 32'(first_fail_stim), 32'(m_cap_stim));
      check("cap_resp", 32'(first_fail_resp), 32'(m_cap_resp));
`endif
   endtask

   // One clock: drive inputs, take the edge, update the model, sample 1ns later.
   task automatic cyc(input bit r, input bit s, input bit p, input bit v,
                      input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] rs);
      rst = r; start = s; stop = p; in_valid = v; stim = st; resp = rs;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      rst = 1; start = 0; stop = 0; in_valid = 0; stim = '0; resp = '0;
      m_mode = 0; model_clear();

      // Reset and quiet idle.
      cyc(1, 0, 0, 0, '0, '0);
      cyc(1, 0, 0, 0, '0, '0);
      idle(3);
      check("idle_ready", 32'(in_ready), 0);
      check("idle_busy",  32'(busy), 0);
      check("idle_done",  32'(done), 0);
      check("idle_pass",  32'(pass_cnt), 0);

      // Two good pairs.
      cyc(0, 1, 0, 0, '0, '0);
      cyc(0, 0, 0, 1, 1'b0, 1'b1);
      cyc(0, 0, 0, 1, 1'b1, 1'b0);
      cyc(0, 0, 1, 0, '0, '0);
      idle(2);
      check("good_done",  32'(done), 1);
      check("good_pass",  32'(pass_cnt), 2);
      check("good_fail",  32'(fail_cnt), 0);
      check("good_error", 32'(error), 0);

      // Failing window, stop with last pair.
      cyc(0, 1, 0, 0, '0, '0);
      cyc(0, 0, 0, 1, 1'b0, 1'b1);
      cyc(0, 0, 0, 1, 1'b1, 1'b1);
      cyc(0, 0, 1, 1, 1'b0, 1'b0);
      cyc(0, 0, 0, 0, '0, '0);
      check("fail_done0", 32'(done), 1);
      check("fail_pass",  32'(pass_cnt), 1);
      check("fail_fail",  32'(fail_cnt), 2);
      check("fail_error", 32'(error), 1);
`ifdef CHECKER_CAPTURE_EN
      check("fail_cstim", 32'(first_fail_stim), 1);
      check("fail_cresp", 32'(first_fail_resp), 1);
`endif
      // Restart straight out of DONE clears everything.
      cyc(0, 1, 0, 0, '0, '0);
      check("restart_err",  32'(error), 0);
      check("restart_fail", 32'(fail_cnt), 0);
      check("restart_run",  32'(in_ready), 1);

      // Saturation: nine good pairs into a 3-bit counter.
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, WIDTH'(i), ~WIDTH'(i));
      cyc(0, 0, 1, 0, '0, '0);
      idle(2);
      check("sat_pass", 32'(pass_cnt), MAXC);

      // Reset mid-window, with a pair in flight.
      cyc(0, 1, 0, 0, '0, '0);
      cyc(0, 0, 0, 1, 1'b0, 1'b1);
      cyc(0, 0, 0, 1, 1'b1, 1'b0);
      cyc(1, 0, 0, 1, 1'b1, 1'b1);
      check("rst_pass",  32'(pass_cnt), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_ready", 32'(in_ready), 0);
      idle(2);
      check("rst_flush", 32'(pass_cnt), 0);

      // Dropped traffic: valid in IDLE, stop in IDLE, valid in DONE.
      cyc(0, 0, 1, 1, 1'b0, 1'b1);
      cyc(0, 0, 0, 1, 1'b1, 1'b1);
      idle(1);
      check("idle_drop_pass", 32'(pass_cnt), 0);
      check("idle_drop_fail", 32'(fail_cnt), 0);
      cyc(0, 1, 0, 0, '0, '0);
      cyc(0, 0, 0, 1, 1'b0, 1'b0);
      cyc(0, 0, 1, 0, '0, '0);
      idle(1);
      cyc(0, 0, 0, 1, 1'b1, 1'b1);
      cyc(0, 0, 1, 1, 1'b0, 1'b0);
      idle(1);
      check("done_drop_fail", 32'(fail_cnt), 1);
      check("done_hold",      32'(done), 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [WIDTH-1:0] st;
         logic [WIDTH-1:0] rs;
         st = WIDTH'($urandom);
         rs = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : ~st;
         cyc($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 19) == 0, 1'($urandom), st, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
